inst_prefetch_unit: RTL

Instruction fetch front end for the MIPS 5-stage pipeline, sitting directly upstream of the IF/ID register. Issues sequential instruction-memory requests over a request/acknowledge handshake and buffers returned instructions, tagged with PC and PC+4, in a small FIFO. Presents them to the ID stage over a valid/ready handshake. Handles branch/jump redirects by flushing the FIFO and discarding any in-flight response.

---
 rtl/mips_pipe_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/inst_prefetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pipe_pkg;

  // Fetch FSM: no request, request outstanding, request outstanding whose
  // response must be thrown away because a redirect overtook it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // One buffered instruction as handed to the ID stage (96 bits).
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with clear and a registered head.
// The head register always holds the oldest entry, so an entry pushed into an
// empty FIFO becomes visible the cycle after the push (no bypass).
module fetch_fifo
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_after_pop;
  logic          pop_ok;
  fetch_entry_t  head_nxt;

  // A pop on an empty FIFO is ignored so the pointers can never skew.
  assign pop_ok          = pop & (count != '0);
  assign rd_ptr_nxt      = rd_ptr + PW'(pop_ok);
  assign count_after_pop = count - CW'(pop_ok);
  assign valid           = (count != '0);

  // Next head: oldest remaining stored entry, else the entry being pushed.
  always_comb begin
    head_nxt = head;
    if (!clear) begin
      if (count_after_pop != '0) begin
        head_nxt = mem[rd_ptr_nxt];
      end else if (push) begin
        head_nxt = wdata;
      end
    end
  end

  // Entry storage; no reset needed since count qualifies every read.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and head register; clear keeps the stale head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '{inst: INST_NOP, pc: 32'h0, pc_next: 32'h0};
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_after_pop + CW'(push);
      head   <= head_nxt;
    end
  end

endmodule

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: sequential fetch over a req/ack memory port,
// buffered in a FIFO and presented to ID with PC and PC+4.
//
// Handshakes:
//  - memory side: inst_ren/inst_addr are registered and held until inst_ack;
//    inst_ack is always accepted (memory cannot be stalled), inst_data valid
//    with it.
//  - ID side: an entry transfers when if_valid & if_ready & cpu_en and no
//    redirect is present in the same cycle.
// A request only issues when the FIFO has room for its response
// (count + outstanding < DEPTH), so a push can never hit a full FIFO.
module inst_prefetch_unit
  import mips_pipe_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        cpu_rst_n,
  input  logic        cpu_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        inst_ren,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_next
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_inc;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_upd;
  logic          push;
  logic          pop;
  logic          idle_issue_ok;
  logic          ack_issue_ok;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign redirect_pc  = redirect_addr & ~32'h3;
  assign fetch_pc_inc = fetch_pc + PC_STEP;

  // In WAIT, fetch_pc is the address of the outstanding request.
  assign push       = (state == WAIT) & inst_ack & ~redirect_valid;
  assign pop        = if_valid & if_ready & cpu_en & ~redirect_valid;
  assign push_entry = '{inst: inst_data, pc: fetch_pc, pc_next: fetch_pc_inc};

  // Occupancy after this cycle's push/pop, used to decide back-to-back issue.
  assign count_upd     = count + CW'(push) - CW'(pop);
  assign idle_issue_ok = cpu_en & ~redirect_valid & (count < DEPTH_C);
  assign ack_issue_ok  = cpu_en & ~redirect_valid & (count_upd < DEPTH_C);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (cpu_rst_n),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .valid (if_valid),
    .count (count)
  );

  assign if_inst    = head.inst;
  assign if_pc      = head.pc;
  assign if_pc_next = head.pc_next;

  // Fetch FSM, PC counter and request register; redirect overrides all.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= IDLE;
      inst_ren  <= 1'b0;
      inst_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      case (state)
        WAIT: begin
          if (inst_ack) begin
            state     <= IDLE;
            inst_ren  <= 1'b0;
            inst_addr <= redirect_pc;
          end else begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (inst_ack) begin
            state     <= IDLE;
            inst_ren  <= 1'b0;
            inst_addr <= redirect_pc;
          end
        end
        default: begin
          state     <= IDLE;
          inst_ren  <= 1'b0;
          inst_addr <= redirect_pc;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (idle_issue_ok) begin
            state     <= WAIT;
            inst_ren  <= 1'b1;
            inst_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (inst_ack) begin
            fetch_pc <= fetch_pc_inc;
            if (ack_issue_ok) begin
              inst_addr <= fetch_pc_inc;
            end else begin
              state    <= IDLE;
              inst_ren <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (inst_ack) begin
            state    <= IDLE;
            inst_ren <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          inst_ren <= 1'b0;
        end
      endcase
    end
  end

endmodule
